// File: rtl/lighthouse_pkg.sv
// Shared definitions for the lighthouse pulse decoder: FSM encodings,
// sync code bit positions, default timing constants and the sync code ladder.
// The optional OOTX decoder is enabled with LIGHTHOUSE_OOTX_EN.
package lighthouse_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    SWEPT    = 2'd2
  } lh_state_t;

  typedef enum logic [1:0] {
    OOTX_HUNT  = 2'd0,
    OOTX_SHIFT = 2'd1,
    OOTX_STUFF = 2'd2
  } ootx_state_t;

  // Bit positions inside the 3-bit sync code {skip, data, axis}
  localparam int CODE_SKIP = 2;
  localparam int CODE_DATA = 1;
  localparam int CODE_AXIS = 0;

  // Default timing in 48 MHz clock cycles
  localparam int DEF_SYNC_BASE    = 2750;
  localparam int DEF_SYNC_STEP    = 500;
  localparam int DEF_SWEEP_MAX    = 2400;
  localparam int DEF_LOCK_TIMEOUT = 432000;

  localparam logic [19:0] SINCE_MAX = 20'hFFFFF;

  // Comparator ladder: largest i in 0..7 with len >= base + i*step.
  // Only meaningful when len is already known to be in the sync range.
  function automatic logic [2:0] sync_code_of(input logic [23:0] len,
                                              input int base,
                                              input int step);
    logic [2:0] code;
    code = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (32'(len) >= 32'(base + i * step)) code = 3'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/lighthouse_decoder_ootx_decoder.sv
// OOTX bit-stream deframer: hunts for 17 zeros then a 1, shifts 16-bit
// words MSB first, and checks the stuffing 1 after each word.
// Compiled only when LIGHTHOUSE_OOTX_EN is defined.
`ifdef LIGHTHOUSE_OOTX_EN
module ootx_decoder
  import lighthouse_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_valid,
  input  logic        data_bit,
  input  logic        clear,
  output logic        word_valid,
  output logic [15:0] word,
  output logic        error
);

  ootx_state_t state, next_state;
  logic [4:0]  zero_cnt, next_zero_cnt;
  logic [15:0] shift_reg, next_shift;
  logic [3:0]  bit_cnt, next_bit_cnt;
  logic        fire_word, fire_error;

  // Next-state logic: framing hunt, word shift and stuffing check
  always_comb begin
    next_state    = state;
    next_zero_cnt = zero_cnt;
    next_shift    = shift_reg;
    next_bit_cnt  = bit_cnt;
    fire_word     = 1'b0;
    fire_error    = 1'b0;
    if (clear) begin
      next_state    = OOTX_HUNT;
      next_zero_cnt = 5'd0;
      next_bit_cnt  = 4'd0;
    end else if (bit_valid) begin
      case (state)
        OOTX_HUNT: begin
          if (data_bit) begin
            if (zero_cnt == 5'd17) begin
              next_state   = OOTX_SHIFT;
              next_bit_cnt = 4'd0;
            end
            next_zero_cnt = 5'd0;
          end else if (zero_cnt != 5'd17) begin
            next_zero_cnt = zero_cnt + 5'd1;
          end
        end
        OOTX_SHIFT: begin
          next_shift   = {shift_reg[14:0], data_bit};
          next_bit_cnt = bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) begin
            fire_word  = 1'b1;
            next_state = OOTX_STUFF;
          end
        end
        OOTX_STUFF: begin
          if (data_bit) begin
            next_state   = OOTX_SHIFT;
            next_bit_cnt = 4'd0;
          end else begin
            // The bad stuffing zero already counts toward the next preamble
            fire_error    = 1'b1;
            next_state    = OOTX_HUNT;
            next_zero_cnt = 5'd1;
          end
        end
        default: next_state = OOTX_HUNT;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= OOTX_HUNT;
      zero_cnt   <= 5'd0;
      shift_reg  <= 16'd0;
      bit_cnt    <= 4'd0;
      word_valid <= 1'b0;
      word       <= 16'd0;
      error      <= 1'b0;
    end else begin
      state      <= next_state;
      zero_cnt   <= next_zero_cnt;
      shift_reg  <= next_shift;
      bit_cnt    <= next_bit_cnt;
      word_valid <= fire_word;
      error      <= fire_error;
      if (fire_word) word <= next_shift;
    end
  end

endmodule
`endif

// File: rtl/lighthouse_decoder.sv
// Lighthouse pulse classifier: decodes sync codes, tracks lock, and reports
// the first sweep hit after each sync relative to the sync rising edge.
// Define LIGHTHOUSE_OOTX_EN to build the OOTX deframer; otherwise the OOTX
// outputs are tied to zero.
//
// Strobe semantics: sync_valid, sweep_valid, pulse_reject and
// ootx_word_valid are single-cycle valids with no ready; the consumer must
// take them on the cycle they assert. Their data outputs hold until the next
// strobe of the same kind.
module lighthouse_decoder
  import lighthouse_pkg::*;
#(
  parameter int SYNC_BASE    = DEF_SYNC_BASE,
  parameter int SYNC_STEP    = DEF_SYNC_STEP,
  parameter int SWEEP_MAX    = DEF_SWEEP_MAX,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        high_end_strobe,
  input  logic        low_end_strobe,
  input  logic [23:0] pulse_length,
  output logic        sync_valid,
  output logic [2:0]  sync_code,
  output logic        sweep_valid,
  output logic        sweep_axis,
  output logic [19:0] sweep_ticks,
  output logic [11:0] sweep_width,
  output logic        pulse_reject,
  output logic        locked,
  output logic        ootx_word_valid,
  output logic [15:0] ootx_word,
  output logic        ootx_error
);

  localparam logic [23:0] SWEEP_MAX_L = 24'(SWEEP_MAX);
  localparam logic [23:0] SYNC_LO     = 24'(SYNC_BASE);
  localparam logic [23:0] SYNC_HI     = 24'(SYNC_BASE + 8 * SYNC_STEP);
  localparam logic [19:0] TIMEOUT_L   = 20'(LOCK_TIMEOUT);

  lh_state_t   state, next_state;
  logic [19:0] since_sync;
  logic        cur_axis;
  logic        is_sweep, is_sync, timed_out;
  logic [2:0]  code;
  logic [23:0] since_ext;
  logic [19:0] ticks_calc;
  logic        sync_fire, sweep_fire, reject_fire, relock;

  // Low-gap strobes are reserved for future gap checks and deliberately ignored
  logic unused_low_end;
  assign unused_low_end = low_end_strobe;

  // Pulse classification and sweep timing from the current pulse length
  always_comb begin
    is_sweep   = pulse_length < SWEEP_MAX_L;
    is_sync    = (pulse_length >= SYNC_LO) && (pulse_length < SYNC_HI);
    code       = sync_code_of(pulse_length, SYNC_BASE, SYNC_STEP);
    since_ext  = {4'd0, since_sync};
    ticks_calc = (since_ext >= pulse_length) ? 20'(since_ext - pulse_length) : 20'd0;
  end

  // Lock FSM next state; a valid skip=0 sync overrides a same-cycle timeout
  always_comb begin
    next_state  = state;
    sync_fire   = 1'b0;
    sweep_fire  = 1'b0;
    reject_fire = 1'b0;
    relock      = 1'b0;
    timed_out   = (state != UNLOCKED) && (since_sync >= TIMEOUT_L);
    if (timed_out) next_state = UNLOCKED;
    if (high_end_strobe) begin
      if (is_sweep) begin
        if (state == LOCKED && !timed_out) begin
          sweep_fire = 1'b1;
          next_state = SWEPT;
        end
      end else if (is_sync) begin
        sync_fire = 1'b1;
        if (!code[CODE_SKIP]) begin
          relock     = 1'b1;
          next_state = LOCKED;
        end
      end else begin
        reject_fire = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= UNLOCKED;
    else       state <= next_state;
  end

  // Sync-relative timer, current axis, and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      since_sync   <= 20'd0;
      cur_axis     <= 1'b0;
      sync_valid   <= 1'b0;
      sync_code    <= 3'd0;
      sweep_valid  <= 1'b0;
      sweep_axis   <= 1'b0;
      sweep_ticks  <= 20'd0;
      sweep_width  <= 12'd0;
      pulse_reject <= 1'b0;
      locked       <= 1'b0;
    end else begin
      if (relock) begin
        since_sync <= pulse_length[19:0];
        cur_axis   <= code[CODE_AXIS];
      end else if (since_sync != SINCE_MAX) begin
        since_sync <= since_sync + 20'd1;
      end
      sync_valid   <= sync_fire;
      sweep_valid  <= sweep_fire;
      pulse_reject <= reject_fire;
      locked       <= (next_state != UNLOCKED);
      if (sync_fire) sync_code <= code;
      if (sweep_fire) begin
        sweep_axis  <= cur_axis;
        sweep_ticks <= ticks_calc;
        sweep_width <= pulse_length[11:0];
      end
    end
  end

`ifdef LIGHTHOUSE_OOTX_EN
  logic ootx_bit_valid, ootx_clear;
  assign ootx_bit_valid = relock;
  assign ootx_clear     = (state != UNLOCKED) && (next_state == UNLOCKED);

  ootx_decoder u_ootx (
    .clk        (clk),
    .reset      (reset),
    .bit_valid  (ootx_bit_valid),
    .data_bit   (code[CODE_DATA]),
    .clear      (ootx_clear),
    .word_valid (ootx_word_valid),
    .word       (ootx_word),
    .error      (ootx_error)
  );
`else
  assign ootx_word_valid = 1'b0;
  assign ootx_word       = 16'd0;
  assign ootx_error      = 1'b0;
`endif

endmodule
